// File: rtl/mem_port_arbiter.sv
// Two-master, one-slave memory port arbiter: round-robin request grant with a lock that
// holds a stalled request in place, and in-order response routing through a small ID FIFO.
module mem_port_arbiter #(
  parameter int ADDR_WIDTH      = 32,
  parameter int DATA_WIDTH      = 32,
  parameter int MAX_OUTSTANDING = 4
) (
  input  logic                      clk,
  input  logic                      rst,
  input  logic                      m0_req_valid,
  output logic                      m0_req_ready,
  input  logic [ADDR_WIDTH-1:0]     m0_req_addr,
  input  logic                      m0_req_we,
  input  logic [DATA_WIDTH-1:0]     m0_req_wdata,
  input  logic [DATA_WIDTH/8-1:0]   m0_req_be,
  output logic                      m0_rsp_valid,
  output logic [DATA_WIDTH-1:0]     m0_rsp_rdata,
  input  logic                      m1_req_valid,
  output logic                      m1_req_ready,
  input  logic [ADDR_WIDTH-1:0]     m1_req_addr,
  input  logic                      m1_req_we,
  input  logic [DATA_WIDTH-1:0]     m1_req_wdata,
  input  logic [DATA_WIDTH/8-1:0]   m1_req_be,
  output logic                      m1_rsp_valid,
  output logic [DATA_WIDTH-1:0]     m1_rsp_rdata,
  output logic                      s_req_valid,
  input  logic                      s_req_ready,
  output logic [ADDR_WIDTH-1:0]     s_req_addr,
  output logic                      s_req_we,
  output logic [DATA_WIDTH-1:0]     s_req_wdata,
  output logic [DATA_WIDTH/8-1:0]   s_req_be,
  input  logic                      s_rsp_valid,
  input  logic [DATA_WIDTH-1:0]     s_rsp_rdata,
  output logic                      err_unexpected_rsp
);

  localparam int PTR_W = $clog2(MAX_OUTSTANDING);
  localparam int CNT_W = PTR_W + 1;

  logic             rr_last_reg;
  logic             lock_valid_reg;
  logic             lock_id_reg;
  logic             err_reg;
  logic [PTR_W-1:0] wr_ptr_reg;
  logic [PTR_W-1:0] rd_ptr_reg;
  logic [CNT_W-1:0] count_reg;
  logic [CNT_W-1:0] count_next;
  logic             id_mem [MAX_OUTSTANDING];

  logic grant;
  logic grant_valid;
  logic fifo_full;
  logic fifo_empty;
  logic fire;
  logic pop;
  logic head_id;

  assign fifo_full  = (count_reg == CNT_W'(MAX_OUTSTANDING));
  assign fifo_empty = (count_reg == '0);

  // A stalled request stays locked to its master so the slave never sees it switch.
  always_comb begin
    grant = 1'b0;
    if (lock_valid_reg)
      grant = lock_id_reg;
    else if (m0_req_valid && m1_req_valid)
      grant = ~rr_last_reg;
    else if (m1_req_valid)
      grant = 1'b1;
  end

  assign grant_valid  = grant ? m1_req_valid : m0_req_valid;
  assign s_req_valid  = grant_valid & ~fifo_full;
  assign fire         = s_req_valid & s_req_ready;
  assign m0_req_ready = fire & ~grant;
  assign m1_req_ready = fire & grant;

  assign s_req_addr  = grant ? m1_req_addr  : m0_req_addr;
  assign s_req_we    = grant ? m1_req_we    : m0_req_we;
  assign s_req_wdata = grant ? m1_req_wdata : m0_req_wdata;
  assign s_req_be    = grant ? m1_req_be    : m0_req_be;

  // The FIFO head is read combinationally so responses route with zero added latency.
  assign head_id      = id_mem[rd_ptr_reg];
  assign pop          = s_rsp_valid & ~fifo_empty;
  assign m0_rsp_valid = pop & ~head_id;
  assign m1_rsp_valid = pop & head_id;
  assign m0_rsp_rdata = s_rsp_rdata;
  assign m1_rsp_rdata = s_rsp_rdata;
  assign err_unexpected_rsp = err_reg;

  always_comb begin
    count_next = count_reg;
    case ({fire, pop})
      2'b10:   count_next = count_reg + CNT_W'(1);
      2'b01:   count_next = count_reg - CNT_W'(1);
      default: count_next = count_reg;
    endcase
  end

  always_ff @(posedge clk) begin
    if (fire)
      id_mem[wr_ptr_reg] <= grant;
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      rr_last_reg    <= 1'b1;
      lock_valid_reg <= 1'b0;
      lock_id_reg    <= 1'b0;
      err_reg        <= 1'b0;
      wr_ptr_reg     <= '0;
      rd_ptr_reg     <= '0;
      count_reg      <= '0;
    end else begin
      if (fire) begin
        rr_last_reg    <= grant;
        lock_valid_reg <= 1'b0;
        wr_ptr_reg     <= wr_ptr_reg + PTR_W'(1);
      end else if (s_req_valid) begin
        lock_valid_reg <= 1'b1;
        lock_id_reg    <= grant;
      end
      if (pop)
        rd_ptr_reg <= rd_ptr_reg + PTR_W'(1);
      if (s_rsp_valid && fifo_empty)
        err_reg <= 1'b1;
      count_reg <= count_next;
    end
  end

endmodule

// File: tb/tb_mem_port_arbiter.sv
// Directed bench for mem_port_arbiter: a cycle table for grant/lock/routing from reset,
// then hand sequences for FIFO full, lock ordering and unexpected responses.
module tb_mem_port_arbiter;

  logic        clk = 1'b0;
  logic        rst;
  logic        m0_req_valid, m0_req_ready, m0_req_we, m0_rsp_valid;
  logic [31:0] m0_req_addr, m0_req_wdata, m0_rsp_rdata;
  logic [3:0]  m0_req_be;
  logic        m1_req_valid, m1_req_ready, m1_req_we, m1_rsp_valid;
  logic [31:0] m1_req_addr, m1_req_wdata, m1_rsp_rdata;
  logic [3:0]  m1_req_be;
  logic        s_req_valid, s_req_ready, s_req_we, s_rsp_valid, err_unexpected_rsp;
  logic [31:0] s_req_addr, s_req_wdata, s_rsp_rdata;
  logic [3:0]  s_req_be;

  int checks = 0;
  int errors = 0;

  always #5 clk = ~clk;

  mem_port_arbiter dut (
    .clk(clk), .rst(rst),
    .m0_req_valid(m0_req_valid), .m0_req_ready(m0_req_ready), .m0_req_addr(m0_req_addr),
    .m0_req_we(m0_req_we), .m0_req_wdata(m0_req_wdata), .m0_req_be(m0_req_be),
    .m0_rsp_valid(m0_rsp_valid), .m0_rsp_rdata(m0_rsp_rdata),
    .m1_req_valid(m1_req_valid), .m1_req_ready(m1_req_ready), .m1_req_addr(m1_req_addr),
    .m1_req_we(m1_req_we), .m1_req_wdata(m1_req_wdata), .m1_req_be(m1_req_be),
    .m1_rsp_valid(m1_rsp_valid), .m1_rsp_rdata(m1_rsp_rdata),
    .s_req_valid(s_req_valid), .s_req_ready(s_req_ready), .s_req_addr(s_req_addr),
    .s_req_we(s_req_we), .s_req_wdata(s_req_wdata), .s_req_be(s_req_be),
    .s_rsp_valid(s_rsp_valid), .s_rsp_rdata(s_rsp_rdata),
    .err_unexpected_rsp(err_unexpected_rsp)
  );

  typedef struct {
    logic        m0v, m1v, sr, rsp;
    logic        sv;
    logic [31:0] addr;
    logic        r0, r1, p0, p1;
  } vec_t;

  vec_t vecs [12];

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %h expected %h", name, act, exp);
    end else begin
      $display("ok   %s: %h", name, act);
    end
  endtask

  task automatic drive(input logic v0, input logic v1, input logic sr, input logic rsp);
    @(negedge clk);
    m0_req_valid = v0;
    m1_req_valid = v1;
    s_req_ready  = sr;
    s_rsp_valid  = rsp;
    s_rsp_rdata  = s_rsp_rdata + 32'h1;
    #1;
  endtask

  task automatic do_reset();
    @(negedge clk);
    rst = 1'b1;
    m0_req_valid = 1'b0; m1_req_valid = 1'b0; s_req_ready = 1'b0; s_rsp_valid = 1'b0;
    @(negedge clk);
    @(negedge clk);
    rst = 1'b0;
  endtask

  initial begin
    // m0v m1v sr rsp | sv addr r0 r1 p0 p1
    vecs[0]  = '{1'b0, 1'b0, 1'b1, 1'b0, 1'b0, 32'h100, 1'b0, 1'b0, 1'b0, 1'b0};
    vecs[1]  = '{1'b1, 1'b1, 1'b1, 1'b0, 1'b1, 32'h100, 1'b1, 1'b0, 1'b0, 1'b0};
    vecs[2]  = '{1'b1, 1'b1, 1'b1, 1'b0, 1'b1, 32'h200, 1'b0, 1'b1, 1'b0, 1'b0};
    vecs[3]  = '{1'b1, 1'b1, 1'b1, 1'b1, 1'b1, 32'h100, 1'b1, 1'b0, 1'b1, 1'b0};
    vecs[4]  = '{1'b1, 1'b1, 1'b0, 1'b1, 1'b1, 32'h200, 1'b0, 1'b0, 1'b0, 1'b1};
    vecs[5]  = '{1'b1, 1'b1, 1'b0, 1'b0, 1'b1, 32'h200, 1'b0, 1'b0, 1'b0, 1'b0};
    vecs[6]  = '{1'b1, 1'b1, 1'b1, 1'b1, 1'b1, 32'h200, 1'b0, 1'b1, 1'b1, 1'b0};
    vecs[7]  = '{1'b1, 1'b1, 1'b1, 1'b0, 1'b1, 32'h100, 1'b1, 1'b0, 1'b0, 1'b0};
    vecs[8]  = '{1'b0, 1'b1, 1'b1, 1'b1, 1'b1, 32'h200, 1'b0, 1'b1, 1'b0, 1'b1};
    vecs[9]  = '{1'b0, 1'b0, 1'b1, 1'b1, 1'b0, 32'h100, 1'b0, 1'b0, 1'b1, 1'b0};
    vecs[10] = '{1'b0, 1'b0, 1'b1, 1'b1, 1'b0, 32'h100, 1'b0, 1'b0, 1'b0, 1'b1};
    vecs[11] = '{1'b0, 1'b0, 1'b1, 1'b0, 1'b0, 32'h100, 1'b0, 1'b0, 1'b0, 1'b0};

    m0_req_addr = 32'h100; m0_req_we = 1'b0; m0_req_wdata = 32'hAAAA0000; m0_req_be = 4'hF;
    m1_req_addr = 32'h200; m1_req_we = 1'b1; m1_req_wdata = 32'hBBBB0000; m1_req_be = 4'h3;
    s_rsp_rdata = 32'hD0000000;
    do_reset();

    drive(1'b0, 1'b0, 1'b1, 1'b0);
    check("reset_idle", {58'd0, s_req_valid, m0_req_ready, m1_req_ready,
                         m0_rsp_valid, m1_rsp_valid, err_unexpected_rsp}, 64'd0);

    // Grant, lock, round-robin and response routing across a FIFO pointer wrap.
    for (int i = 0; i < 12; i++) begin
      drive(vecs[i].m0v, vecs[i].m1v, vecs[i].sr, vecs[i].rsp);
      check($sformatf("vec%0d", i),
            {27'd0, s_req_valid, s_req_addr, m0_req_ready, m1_req_ready, m0_rsp_valid, m1_rsp_valid},
            {27'd0, vecs[i].sv, vecs[i].addr, vecs[i].r0, vecs[i].r1, vecs[i].p0, vecs[i].p1});
    end
    check("err_after_table", {63'd0, err_unexpected_rsp}, 64'd0);

    // Muxed fields follow the grant (m1 is alone, so it is granted).
    drive(1'b0, 1'b1, 1'b0, 1'b0);
    check("m1_fields", {27'd0, s_req_we, s_req_be, s_req_wdata}, {27'd0, 1'b1, 4'h3, 32'hBBBB0000});
    do_reset();

    // FIFO full: slave never answers, so exactly four fires.
    for (int k = 0; k < 6; k++) begin
      drive(1'b1, 1'b0, 1'b1, 1'b0);
      check($sformatf("full_fire%0d", k), {63'd0, s_req_valid & s_req_ready}, {63'd0, k < 4});
    end
    drive(1'b1, 1'b0, 1'b1, 1'b1);
    check("full_pop_cycle", {62'd0, s_req_valid, m0_rsp_valid}, {62'd0, 1'b0, 1'b1});
    check("rsp_rdata", {m0_rsp_rdata, m1_rsp_rdata}, {s_rsp_rdata, s_rsp_rdata});
    drive(1'b1, 1'b0, 1'b1, 1'b0);
    check("full_release", {62'd0, s_req_valid, m0_req_ready}, {62'd0, 1'b1, 1'b1});
    for (int k = 0; k < 4; k++) begin
      drive(1'b0, 1'b0, 1'b1, 1'b1);
      check($sformatf("full_drain%0d", k), {62'd0, m0_rsp_valid, m1_rsp_valid}, {62'd0, 1'b1, 1'b0});
    end

    // Lock from reset: m0 wins first, held through three stall cycles, then m1.
    do_reset();
    for (int k = 0; k < 3; k++) begin
      drive(1'b1, 1'b1, 1'b0, 1'b0);
      check($sformatf("lock_stall%0d", k), {29'd0, s_req_valid, s_req_addr, m0_req_ready, m1_req_ready},
            {29'd0, 1'b1, 32'h100, 1'b0, 1'b0});
    end
    drive(1'b1, 1'b1, 1'b1, 1'b0);
    check("lock_fire_m0", {30'd0, s_req_addr, m0_req_ready, m1_req_ready}, {30'd0, 32'h100, 1'b1, 1'b0});
    drive(1'b0, 1'b1, 1'b1, 1'b0);
    check("lock_fire_m1", {30'd0, s_req_addr, m0_req_ready, m1_req_ready}, {30'd0, 32'h200, 1'b0, 1'b1});
    drive(1'b0, 1'b0, 1'b1, 1'b1);
    check("lock_rsp_m0", {62'd0, m0_rsp_valid, m1_rsp_valid}, {62'd0, 1'b1, 1'b0});
    drive(1'b0, 1'b0, 1'b1, 1'b1);
    check("lock_rsp_m1", {62'd0, m0_rsp_valid, m1_rsp_valid}, {62'd0, 1'b0, 1'b1});

    // Unexpected response with the FIFO empty sets a sticky error.
    drive(1'b0, 1'b0, 1'b1, 1'b1);
    check("unexp_no_route", {62'd0, m0_rsp_valid, m1_rsp_valid}, 64'd0);
    drive(1'b0, 1'b0, 1'b1, 1'b0);
    check("unexp_err_set", {63'd0, err_unexpected_rsp}, 64'd1);
    drive(1'b0, 1'b0, 1'b1, 1'b0);
    drive(1'b0, 1'b0, 1'b1, 1'b0);
    check("unexp_err_sticky", {63'd0, err_unexpected_rsp}, 64'd1);
    do_reset();
    #1;
    check("unexp_err_cleared", {63'd0, err_unexpected_rsp}, 64'd0);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
